// File: rtl/lbist_response_comparator_if.sv
// Bus bundle between the LBIST response comparator and its surroundings:
// the Accumulator/eNVM read port, the Diagnostic loop chains and hybrid_bist.
// The slave modport is the comparator; the master modport is the environment
// that issues start, supplies row data and consumes the results.
interface lbist_response_comparator_if #(
    parameter int SYSTOLIC_SIZE     = 8,
    parameter int PARTIAL_SUM_WIDTH = 19,
    parameter int ADDR_WIDTH        = $clog2(SYSTOLIC_SIZE)
);
    logic                                       start;
    logic                                       acc_rd_en;
    logic [ADDR_WIDTH-1:0]                      acc_rd_addr;
    logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] partial_sum_flat;
    logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] answer_flat;
    logic [SYSTOLIC_SIZE-1:0]                   compared_results;
    logic                                       cmp_valid;
    logic                                       diagnosis_start_en;
    logic [SYSTOLIC_SIZE-1:0]                   col_fault_summary;
    logic [ADDR_WIDTH:0]                        fault_row_count;
    logic                                       busy;
    logic                                       done;
    logic                                       pass;

    modport master (
        output start,
        output partial_sum_flat,
        output answer_flat,
        input  acc_rd_en,
        input  acc_rd_addr,
        input  compared_results,
        input  cmp_valid,
        input  diagnosis_start_en,
        input  col_fault_summary,
        input  fault_row_count,
        input  busy,
        input  done,
        input  pass
    );

    modport slave (
        input  start,
        input  partial_sum_flat,
        input  answer_flat,
        output acc_rd_en,
        output acc_rd_addr,
        output compared_results,
        output cmp_valid,
        output diagnosis_start_en,
        output col_fault_summary,
        output fault_row_count,
        output busy,
        output done,
        output pass
    );
endinterface

// File: rtl/lbist_response_comparator.sv
// LBIST response comparator: sweeps every accumulator row, compares each
// column against the golden eNVM answer and reports per-row mismatch vectors,
// a diagnosis start pulse, and sweep-level pass/fail statistics.
module lbist_response_comparator #(
    parameter int SYSTOLIC_SIZE     = 8,
    parameter int PARTIAL_SUM_WIDTH = 19,
    parameter int ADDR_WIDTH        = $clog2(SYSTOLIC_SIZE)
) (
    input logic                        clk,
    input logic                        rst_n,
    lbist_response_comparator_if.slave bus
);
    localparam int FLAT_W = SYSTOLIC_SIZE * PARTIAL_SUM_WIDTH;
    localparam int CNT_W  = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW    = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);
    localparam logic [CNT_W-1:0]      ROW_CNT_MAX = CNT_W'(SYSTOLIC_SIZE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    drain_q, drain_d;
    logic                    start_accept;

    logic                    vld_p1_q;
    logic                    first_p1_q;
    logic                    vld_p2_q;
    logic                    first_p2_q;
    logic [SYSTOLIC_SIZE-1:0] cmp_p2_q;

    logic [SYSTOLIC_SIZE-1:0] col_sum_q;
    logic [CNT_W-1:0]         row_cnt_q;
    logic                     pass_q;

    // Per-column full-width inequality of one accumulator row against its golden row.
    function automatic logic [SYSTOLIC_SIZE-1:0] row_mismatch(
        input logic [FLAT_W-1:0] ps,
        input logic [FLAT_W-1:0] ans
    );
        logic [SYSTOLIC_SIZE-1:0] m;
        m = '0;
        for (int c = 0; c < SYSTOLIC_SIZE; c++) begin
            m[c] = (ps[c*PARTIAL_SUM_WIDTH +: PARTIAL_SUM_WIDTH] !=
                    ans[c*PARTIAL_SUM_WIDTH +: PARTIAL_SUM_WIDTH]);
        end
        return m;
    endfunction

    // Faulty-row counter increment that saturates at the number of rows.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= ROW_CNT_MAX) ? ROW_CNT_MAX : v + CNT_W'(1);
    endfunction

    // A start request only counts while idle; everything else ignores it.
    assign start_accept = (state_q == IDLE) && bus.start;

    // Control state register: sweep state, row address and drain counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
        end
    end

    // Next-state logic: read every row once, wait two cycles for the pipeline, then signal done.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = READ;
                    addr_d  = '0;
                end
            end
            READ: begin
                if (addr_q == LAST_ROW) begin
                    state_d = DRAIN;
                    addr_d  = '0;
                    drain_d = 1'b0;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (drain_q) begin
                    state_d = DONE;
                    drain_d = 1'b0;
                end else begin
                    drain_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.acc_rd_en   = (state_q == READ);
    assign bus.acc_rd_addr = addr_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);

    // Stage 1: the row requested last cycle is now on the data inputs; remember whether it is row 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q   <= 1'b0;
            first_p1_q <= 1'b0;
        end else begin
            vld_p1_q   <= bus.acc_rd_en;
            first_p1_q <= bus.acc_rd_en && (addr_q == '0);
        end
    end

    // Stage 2: register the per-column mismatch vector; it holds while no row is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2_q   <= 1'b0;
            first_p2_q <= 1'b0;
            cmp_p2_q   <= '0;
        end else begin
            vld_p2_q   <= vld_p1_q;
            first_p2_q <= first_p1_q;
            if (vld_p1_q) begin
                cmp_p2_q <= row_mismatch(bus.partial_sum_flat, bus.answer_flat);
            end
        end
    end

    assign bus.compared_results   = cmp_p2_q;
    assign bus.cmp_valid          = vld_p2_q;
    assign bus.diagnosis_start_en = vld_p2_q && first_p2_q;

    // Sweep statistics: cleared by an accepted start, accumulated on each valid row, frozen otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_sum_q <= '0;
            row_cnt_q <= '0;
            pass_q    <= 1'b1;
        end else if (start_accept) begin
            col_sum_q <= '0;
            row_cnt_q <= '0;
            pass_q    <= 1'b1;
        end else if (vld_p2_q) begin
            col_sum_q <= col_sum_q | cmp_p2_q;
            if (|cmp_p2_q) begin
                row_cnt_q <= sat_inc(row_cnt_q);
                pass_q    <= 1'b0;
            end
        end
    end

    assign bus.col_fault_summary = col_sum_q;
    assign bus.fault_row_count   = row_cnt_q;
    assign bus.pass              = pass_q;

endmodule

// File: tb/tb_lbist_response_comparator.sv
// Randomized scoreboard bench for lbist_response_comparator: a row-memory
// model answers reads, expected reads/rows/done are queued at start time and
// popped by independent monitors whenever the DUT presents them.
`timescale 1ns/1ps
module tb_lbist_response_comparator;
    localparam int N  = 8;
    localparam int W  = 19;
    localparam int AW = $clog2(N);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lbist_response_comparator_if #(
        .SYSTOLIC_SIZE(N), .PARTIAL_SUM_WIDTH(W), .ADDR_WIDTH(AW)
    ) bus ();

    lbist_response_comparator #(
        .SYSTOLIC_SIZE(N), .PARTIAL_SUM_WIDTH(W), .ADDR_WIDTH(AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Row memories standing in for the Accumulator and eNVM.
    logic [W-1:0] ps_mem  [N][N];
    logic [W-1:0] ans_mem [N][N];

    typedef struct { int cyc; int addr; } rd_t;
    typedef struct { int cyc; logic [N-1:0] v; logic first; } cmp_t;
    typedef struct { int cyc; logic [N-1:0] sum; int cnt; logic pass; } done_t;
    rd_t   rd_q[$];
    cmp_t  cmp_q[$];
    done_t done_q[$];

    logic [N-1:0] exp_sum;
    int           exp_cnt;
    logic         exp_pass;

    // Memory responder: data for a row read in one cycle appears in the next; noise otherwise.
    logic pend = 1'b0;
    int   pend_addr = 0;
    always @(negedge clk) begin
        pend      = bus.acc_rd_en;
        pend_addr = int'(bus.acc_rd_addr);
    end
    always @(posedge clk) begin
        #1;
        for (int c = 0; c < N; c++) begin
            if (pend) begin
                bus.partial_sum_flat[c*W +: W] = ps_mem[pend_addr][c];
                bus.answer_flat[c*W +: W]      = ans_mem[pend_addr][c];
            end else begin
                bus.partial_sum_flat[c*W +: W] = W'($urandom);
                bus.answer_flat[c*W +: W]      = W'($urandom);
            end
        end
    end

    // Monitors: every read, result row and done pulse must match the head of its queue.
    rd_t   re;
    cmp_t  ce;
    done_t de;
    always @(negedge clk) begin
        if (bus.acc_rd_en) begin
            check("rd_expected", 32'(rd_q.size() != 0), 32'd1);
            if (rd_q.size() != 0) begin
                re = rd_q.pop_front();
                check("rd_addr", 32'(bus.acc_rd_addr), 32'(re.addr));
                check("rd_cycle", cyc, re.cyc);
                check("busy_in_read", 32'(bus.busy), 32'd1);
            end
        end
        if (bus.cmp_valid) begin
            check("row_expected", 32'(cmp_q.size() != 0), 32'd1);
            if (cmp_q.size() != 0) begin
                ce = cmp_q.pop_front();
                check("compared_results", 32'(bus.compared_results), 32'(ce.v));
                check("diag_start", 32'(bus.diagnosis_start_en), 32'(ce.first));
                check("row_cycle", cyc, ce.cyc);
            end
        end
        if (bus.diagnosis_start_en && !bus.cmp_valid) begin
            check("diag_without_valid", 32'd1, 32'd0);
        end
        if (bus.done) begin
            check("done_expected", 32'(done_q.size() != 0), 32'd1);
            if (done_q.size() != 0) begin
                de = done_q.pop_front();
                check("done_cycle", cyc, de.cyc);
                check("done_col_summary", 32'(bus.col_fault_summary), 32'(de.sum));
                check("done_row_count", 32'(bus.fault_row_count), 32'(de.cnt));
                check("done_pass", 32'(bus.pass), 32'(de.pass));
                check("busy_at_done", 32'(bus.busy), 32'd1);
            end
        end
    end

    // Fill the row memories for a scenario and queue the expected responses; c0 is the current cycle index.
    task automatic prepare(input int mode);
        logic [N-1:0] m;
        logic [W-1:0] flip;
        int c0;
        c0 = cyc;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                ans_mem[r][c] = W'($urandom);
                ps_mem[r][c]  = ans_mem[r][c];
                flip = '0;
                flip[$urandom_range(0, W-1)] = 1'b1;
                case (mode)
                    1: if (r == 3 && c == 5) ans_mem[r][c] = ans_mem[r][c] ^ W'(1);
                    2: if (c == 2) ps_mem[r][c] = ps_mem[r][c] ^ flip;
                    3: if ($urandom_range(0, 3) == 0) ps_mem[r][c] = ps_mem[r][c] ^ flip;
                    default: ;
                endcase
            end
        end
        exp_sum = '0;
        exp_cnt = 0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) m[c] = (ps_mem[r][c] != ans_mem[r][c]);
            rd_q.push_back('{cyc: c0 + r + 1, addr: r});
            cmp_q.push_back('{cyc: c0 + r + 3, v: m, first: (r == 0)});
            exp_sum = exp_sum | m;
            if (m != '0) exp_cnt++;
        end
        exp_pass = (exp_cnt == 0);
        done_q.push_back('{cyc: c0 + N + 3, sum: exp_sum, cnt: exp_cnt, pass: exp_pass});
    endtask

    // One sweep, with optional stray start pulses in cycles xa/xb and in the done cycle.
    task automatic run_sweep(input int mode, input int xa, input int xb, input bit start_at_done);
        @(posedge clk); #1;
        prepare(mode);
        bus.start = 1'b1;
        for (int k = 1; k <= N + 5; k++) begin
            @(posedge clk); #1;
            bus.start = (k == xa) || (k == xb) || (start_at_done && k == N + 3);
        end
        bus.start = 1'b0;
        for (int k = 0; k < 20 && done_q.size() != 0; k++) @(posedge clk);
        check("sweep_completed", 32'(done_q.size() == 0 && cmp_q.size() == 0 && rd_q.size() == 0), 32'd1);
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("hold_col_summary", 32'(bus.col_fault_summary), 32'(exp_sum));
        check("hold_row_count", 32'(bus.fault_row_count), 32'(exp_cnt));
        check("hold_pass", 32'(bus.pass), 32'(exp_pass));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_acc_rd_en"}, 32'(bus.acc_rd_en), 32'd0);
        check({tag, "_acc_rd_addr"}, 32'(bus.acc_rd_addr), 32'd0);
        check({tag, "_compared_results"}, 32'(bus.compared_results), 32'd0);
        check({tag, "_cmp_valid"}, 32'(bus.cmp_valid), 32'd0);
        check({tag, "_diag"}, 32'(bus.diagnosis_start_en), 32'd0);
        check({tag, "_col_summary"}, 32'(bus.col_fault_summary), 32'd0);
        check({tag, "_row_count"}, 32'(bus.fault_row_count), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_pass"}, 32'(bus.pass), 32'd1);
    endtask

    // Assert reset asynchronously in cycle 'at' of a faulty sweep and discard its expectations.
    task automatic reset_mid(input int at);
        @(posedge clk); #1;
        prepare(3);
        bus.start = 1'b1;
        for (int k = 1; k <= at; k++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        rd_q.delete();
        cmp_q.delete();
        done_q.delete();
        @(posedge clk); #1;
        check_reset_outputs("rst_held");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_outputs("rst_after");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_outputs("rst_idle");

        run_sweep(0, 0, 0, 1'b0);   // clean sweep
        run_sweep(1, 0, 0, 1'b0);   // single PE fault at row 3, column 5
        run_sweep(2, 0, 0, 1'b0);   // column 2 faulty on every row
        run_sweep(0, 2, 5, 1'b0);   // clean after failing, stray starts while busy
        run_sweep(3, 0, 0, 1'b1);   // random faults, start coincident with done
        run_sweep(0, 0, 0, 1'b1);
        for (int i = 0; i < 4; i++) run_sweep(3, int'($urandom_range(1, N + 2)), 0, 1'(i[0]));

        reset_mid(5);
        run_sweep(1, 0, 0, 1'b0);   // full sweep after a mid-sweep reset
        run_sweep(3, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
